processing_unit_ctx: RTL and testbench



---
 rtl/processing_unit_ctx_pkg.sv | 21 ++
 rtl/processing_unit_ctx_min_index_tree.sv | 28 ++
 rtl/processing_unit_ctx.sv | 233 +++++++++++++++++++++++
 tb/tb_processing_unit_ctx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processing_unit_ctx_pkg.sv
// Shared stage codes and context-store sizing for the union-find processing unit.
package processing_unit_ctx_pkg;

    localparam int STAGE_WIDTH = 3;

    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE                = 3'd0,
        STAGE_MEASUREMENT_LOADING = 3'd1,
        STAGE_GROW                = 3'd2,
        STAGE_MERGE               = 3'd3,
        STAGE_PEELING             = 3'd4,
        STAGE_WRITE_TO_MEM        = 3'd5,
        STAGE_READ_FROM_MEM       = 3'd6
    } stage_t;

    // Saved word: {cluster_parity, parent_vector, root, odd, m}
    function automatic int ctx_word_width(input int nc, input int aw);
        return nc + aw + 3;
    endfunction

endpackage

// File: rtl/processing_unit_ctx_min_index_tree.sv
// Minimum root over valid channels, with a one-hot of the lowest index holding it.
module processing_unit_ctx_min_index_tree #(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 6
) (
    input  logic [WIDTH*CHANNELS-1:0] values,
    input  logic [CHANNELS-1:0]       valid,
    output logic [WIDTH-1:0]          min_value,
    output logic [CHANNELS-1:0]       one_hot,
    output logic                      any_valid
);

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_value = '0;
        one_hot   = '0;
        any_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (valid[i] && (!any_valid || values[i*WIDTH +: WIDTH] < min_value)) begin
                min_value  = values[i*WIDTH +: WIDTH];
                one_hot    = '0;
                one_hot[i] = 1'b1;
                any_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/processing_unit_ctx.sv
// Union-find processing element for one Z ancilla with an internal context store.
module processing_unit_ctx
    import processing_unit_ctx_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 6,
    parameter int NEIGHBOR_COUNT = 6,
    parameter int NUM_CONTEXTS   = 2,
    parameter int SWAP_A         = NEIGHBOR_COUNT - 1,
    parameter int SWAP_B         = NEIGHBOR_COUNT - 2,
    parameter logic [NEIGHBOR_COUNT-1:0] LOCAL_GROW_MASK =
        {2'b11, {(NEIGHBOR_COUNT-2){1'b0}}}
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        measurement,
    output logic                                        measurement_out,
    input  logic [STAGE_WIDTH-1:0]                      global_stage,
    input  logic [NEIGHBOR_COUNT-1:0]                   neighbor_fully_grown,
    input  logic [NEIGHBOR_COUNT-1:0]                   neighbor_is_boundary,
    output logic [NEIGHBOR_COUNT-1:0]                   neighbor_increase,
    output logic [NEIGHBOR_COUNT-1:0]                   neighbor_is_error,
    input  logic [ADDRESS_WIDTH-1:0]                    input_address,
    input  logic                                        local_context_switch,
    input  logic [NEIGHBOR_COUNT*(ADDRESS_WIDTH+3)-1:0] input_data,
    output logic [NEIGHBOR_COUNT*(ADDRESS_WIDTH+3)-1:0] output_data,
    output logic [ADDRESS_WIDTH-1:0]                    root,
    output logic                                        odd,
    output logic                                        busy
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int N  = NEIGHBOR_COUNT;
    localparam int DW = AW + 3;
    localparam int CW = ctx_word_width(N, AW);
    localparam int PW = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1;

    stage_t          stage;
    stage_t          last_stage;
    logic            m;
    logic [N-1:0]    parent_vector;
    logic            cluster_parity;
    logic            already_grown;
    logic            last_local;
    logic [PW-1:0]   ctx_ptr;
    logic [CW-1:0]   store [NUM_CONTEXTS];

    logic [AW*N-1:0] nb_root;
    logic [N-1:0]    nb_parent;
    logic [N-1:0]    nb_odd;
    logic [N-1:0]    nb_cp;

    always_comb begin
        nb_root   = '0;
        nb_parent = '0;
        nb_odd    = '0;
        nb_cp     = '0;
        for (int i = 0; i < N; i++) begin
            nb_root[i*AW +: AW] = input_data[i*DW +: AW];
            nb_parent[i]        = input_data[i*DW + AW];
            nb_odd[i]           = input_data[i*DW + AW + 1];
            nb_cp[i]            = input_data[i*DW + AW + 2];
        end
    end

    always_comb begin
        output_data = '0;
        for (int i = 0; i < N; i++) begin
            output_data[i*DW +: DW] = {cluster_parity, odd, parent_vector[i], root};
        end
    end

    logic [N-1:0]  valid;
    logic [AW-1:0] cand;
    logic [N-1:0]  cand_onehot;
    logic          any_valid;

    assign valid = neighbor_fully_grown & ~neighbor_is_boundary;

    processing_unit_ctx_min_index_tree #(
        .WIDTH    (AW),
        .CHANNELS (N)
    ) u_min (
        .values    (nb_root),
        .valid     (valid),
        .min_value (cand),
        .one_hot   (cand_onehot),
        .any_valid (any_valid)
    );

    logic          boundary_any;
    logic [AW-1:0] root_mod;
    logic          ncp;
    logic [AW-1:0] merge_root;
    logic [N-1:0]  merge_pv;
    logic          merge_odd;
    logic          merge_busy;

    assign boundary_any = |neighbor_is_boundary;
    assign root_mod     = boundary_any ? {1'b0, input_address[AW-2:0]} : root;
    assign ncp          = ^(nb_parent & nb_cp) ^ m;

    always_comb begin
        merge_root = root;
        merge_pv   = parent_vector;
        if (any_valid && cand < root && cand < root_mod) begin
            merge_root = cand;
            merge_pv   = cand_onehot;
        end else if (root_mod < root) begin
            merge_root = root_mod;
            merge_pv   = '0;
        end
        merge_odd = (|parent_vector) ? |(parent_vector & nb_odd)
                                     : (ncp & ~boundary_any);
    end

    assign merge_busy = (merge_root != root) || (merge_pv != parent_vector)
                     || (ncp != cluster_parity) || (merge_odd != odd);

    logic grow_entry;
    assign grow_entry = (stage == STAGE_GROW) && (last_stage != STAGE_GROW);

    always_comb begin
        neighbor_increase = '0;
        if (grow_entry && odd) begin
            neighbor_increase = (last_local && already_grown) ? LOCAL_GROW_MASK : '1;
        end
    end

    logic [N-1:0] border_hi;
    always_comb begin
        border_hi = '0;
        for (int i = 0; i < N; i++) begin
            if (neighbor_is_boundary[i]) begin
                border_hi    = '0;
                border_hi[i] = 1'b1;
            end
        end
    end

    always_comb begin
        neighbor_is_error = '0;
        if (stage == STAGE_PEELING) begin
            neighbor_is_error = (cluster_parity ? parent_vector : '0)
                              | ((parent_vector == '0 && ncp) ? border_hi : '0);
        end
    end

    function automatic logic [N-1:0] swap_ports(input logic [N-1:0] v);
        logic [N-1:0] r;
        r         = v;
        r[SWAP_A] = v[SWAP_B];
        r[SWAP_B] = v[SWAP_A];
        return r;
    endfunction

    logic [CW-1:0] rd_word;
    logic          rd_cp;
    logic [N-1:0]  rd_pv;
    logic [AW-1:0] rd_root;
    logic          rd_odd;
    logic          rd_m;

    assign rd_word = store[ctx_ptr];
    assign rd_cp   = rd_word[CW-1];
    assign rd_pv   = rd_word[CW-2 -: N];
    assign rd_root = rd_word[AW+1:2];
    assign rd_odd  = rd_word[1];
    assign rd_m    = rd_word[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage          <= STAGE_IDLE;
            last_stage     <= STAGE_IDLE;
            m              <= 1'b0;
            root           <= '0;
            parent_vector  <= '0;
            cluster_parity <= 1'b0;
            odd            <= 1'b0;
            busy           <= 1'b0;
            already_grown  <= 1'b0;
            last_local     <= 1'b0;
            ctx_ptr        <= '0;
            for (int k = 0; k < NUM_CONTEXTS; k++) begin
                store[k] <= '0;
            end
        end else begin
            stage      <= stage_t'(global_stage);
            last_stage <= stage;
            case (stage)
                STAGE_MEASUREMENT_LOADING: begin
                    m              <= measurement;
                    cluster_parity <= measurement;
                    odd            <= measurement;
                    root           <= input_address;
                    parent_vector  <= '0;
                end
                STAGE_GROW: begin
                    if (grow_entry) already_grown <= ~already_grown;
                end
                STAGE_MERGE: begin
                    root           <= merge_root;
                    parent_vector  <= merge_pv;
                    cluster_parity <= ncp;
                    odd            <= merge_odd;
                    busy           <= merge_busy;
                end
                STAGE_WRITE_TO_MEM: begin
                    store[ctx_ptr] <= {cluster_parity, parent_vector, root, odd, m};
                    last_local     <= local_context_switch;
                    if (!local_context_switch) begin
                        ctx_ptr <= (ctx_ptr == PW'(NUM_CONTEXTS-1)) ? '0 : ctx_ptr + 1'b1;
                    end
                end
                STAGE_READ_FROM_MEM: begin
                    // A local switch keeps this context but mirrors the swapped ports.
                    if (local_context_switch) begin
                        parent_vector <= swap_ports(parent_vector);
                    end else begin
                        cluster_parity <= rd_cp;
                        parent_vector  <= last_local ? swap_ports(rd_pv) : rd_pv;
                        root           <= rd_root;
                        odd            <= rd_odd;
                        m              <= rd_m;
                    end
                end
                default: ;
            endcase
        end
    end

    assign measurement_out = m;

endmodule

// File: tb/tb_processing_unit_ctx.sv
// Directed and randomized checks of processing_unit_ctx against a behavioural model.
module tb_processing_unit_ctx;
    import processing_unit_ctx_pkg::*;

    localparam int AW   = 6;
    localparam int N    = 6;
    localparam int NCTX = 3;
    localparam int DW   = AW + 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             measurement;
    logic             measurement_out;
    logic [2:0]       global_stage;
    logic [N-1:0]     fully;
    logic [N-1:0]     bnd;
    logic [N-1:0]     neighbor_increase;
    logic [N-1:0]     neighbor_is_error;
    logic [AW-1:0]    input_address;
    logic             local_sw;
    logic [N*DW-1:0]  input_data;
    logic [N*DW-1:0]  output_data;
    logic [AW-1:0]    root;
    logic             odd;
    logic             busy;

    logic [AW-1:0]    nbr_root [N];
    logic [N-1:0]     nbr_par;
    logic [N-1:0]     nbr_odd;
    logic [N-1:0]     nbr_cp;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        input_data = '0;
        for (int i = 0; i < N; i++) begin
            input_data[i*DW +: DW] = {nbr_cp[i], nbr_odd[i], nbr_par[i], nbr_root[i]};
        end
    end

    processing_unit_ctx #(
        .ADDRESS_WIDTH  (AW),
        .NEIGHBOR_COUNT (N),
        .NUM_CONTEXTS   (NCTX)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .measurement          (measurement),
        .measurement_out      (measurement_out),
        .global_stage         (global_stage),
        .neighbor_fully_grown (fully),
        .neighbor_is_boundary (bnd),
        .neighbor_increase    (neighbor_increase),
        .neighbor_is_error    (neighbor_is_error),
        .input_address        (input_address),
        .local_context_switch (local_sw),
        .input_data           (input_data),
        .output_data          (output_data),
        .root                 (root),
        .odd                  (odd),
        .busy                 (busy)
    );

    typedef struct {
        logic         cp;
        logic [N-1:0] pv;
        logic [AW-1:0] root;
        logic         odd;
        logic         m;
    } ctx_t;

    logic [2:0]    md_stage, md_last;
    logic          md_m, md_cp, md_odd, md_busy, md_ag, md_ll;
    logic [AW-1:0] md_root;
    logic [N-1:0]  md_pv;
    int            md_ptr;
    ctx_t          md_store [NCTX];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] swp(input logic [N-1:0] v);
        return {v[4], v[5], v[3:0]};
    endfunction

    function automatic logic [N-1:0] get_pv();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = output_data[i*DW + AW];
        return r;
    endfunction

    function automatic logic model_ncp();
        int c = 0;
        for (int i = 0; i < N; i++) if (nbr_par[i] && nbr_cp[i]) c++;
        return logic'(c % 2) ^ md_m;
    endfunction

    task automatic model_reset();
        md_stage = STAGE_IDLE; md_last = STAGE_IDLE;
        md_m = 0; md_cp = 0; md_odd = 0; md_busy = 0; md_ag = 0; md_ll = 0;
        md_root = 0; md_pv = 0; md_ptr = 0;
        for (int k = 0; k < NCTX; k++) md_store[k] = '{0, 0, 0, 0, 0};
    endtask

    task automatic model_comb(output logic [N-1:0] inc, output logic [N-1:0] err);
        int hi = -1;
        inc = 0;
        err = 0;
        if (md_stage == STAGE_GROW && md_last != STAGE_GROW && md_odd)
            inc = (md_ll && md_ag) ? 6'b110000 : 6'b111111;
        if (md_stage == STAGE_PEELING) begin
            for (int i = 0; i < N; i++) if (bnd[i]) hi = i;
            if (md_cp) err = md_pv;
            if (md_pv == 0 && model_ncp() && hi >= 0) err = err | N'(1 << hi);
        end
    endtask

    task automatic model_step();
        logic [AW-1:0] rm, nroot;
        logic [N-1:0]  npv;
        logic          ncp, nodd;
        int            best;
        case (md_stage)
            STAGE_MEASUREMENT_LOADING: begin
                md_m = measurement; md_cp = measurement; md_odd = measurement;
                md_root = input_address; md_pv = 0;
            end
            STAGE_GROW: if (md_last != STAGE_GROW) md_ag = !md_ag;
            STAGE_MERGE: begin
                best = -1;
                rm = (bnd != 0) ? {1'b0, input_address[AW-2:0]} : md_root;
                for (int i = 0; i < N; i++)
                    if (fully[i] && !bnd[i])
                        if (best < 0 || nbr_root[i] < nbr_root[best]) best = i;
                nroot = md_root;
                npv = md_pv;
                if (best >= 0 && nbr_root[best] < md_root && nbr_root[best] < rm) begin
                    nroot = nbr_root[best];
                    npv = N'(1 << best);
                end else if (rm < md_root) begin
                    nroot = rm;
                    npv = 0;
                end
                ncp = model_ncp();
                nodd = (md_pv != 0) ? ((md_pv & nbr_odd) != 0) : (ncp && bnd == 0);
                md_busy = (nroot != md_root) || (npv != md_pv) || (ncp != md_cp) || (nodd != md_odd);
                md_root = nroot; md_pv = npv; md_cp = ncp; md_odd = nodd;
            end
            STAGE_WRITE_TO_MEM: begin
                md_store[md_ptr] = '{md_cp, md_pv, md_root, md_odd, md_m};
                md_ll = local_sw;
                if (!local_sw) md_ptr = (md_ptr + 1) % NCTX;
            end
            STAGE_READ_FROM_MEM: begin
                if (local_sw) md_pv = swp(md_pv);
                else begin
                    md_cp = md_store[md_ptr].cp;
                    md_pv = md_ll ? swp(md_store[md_ptr].pv) : md_store[md_ptr].pv;
                    md_root = md_store[md_ptr].root;
                    md_odd = md_store[md_ptr].odd;
                    md_m = md_store[md_ptr].m;
                end
            end
            default: ;
        endcase
        md_last = md_stage;
        md_stage = global_stage;
    endtask

    task automatic tick();
        logic [N-1:0]    ei, ee;
        logic [N*DW-1:0] eo;
        #1;
        model_comb(ei, ee);
        check("increase", neighbor_increase, ei);
        check("is_error", neighbor_is_error, ee);
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) eo[i*DW +: DW] = {md_cp, md_odd, md_pv[i], md_root};
        check("root", root, md_root);
        check("odd", odd, md_odd);
        check("busy", busy, md_busy);
        check("m_out", measurement_out, md_m);
        check("out_data", output_data, eo);
    endtask

    task automatic go(input logic [2:0] s);
        global_stage = s;
        tick();
    endtask

    logic [AW-1:0] addrs [3];

    initial begin
        reset = 1; measurement = 0; global_stage = STAGE_IDLE;
        fully = 0; bnd = 0; input_address = 0; local_sw = 0;
        nbr_par = 0; nbr_odd = 0; nbr_cp = 0;
        for (int i = 0; i < N; i++) nbr_root[i] = 0;
        #2 reset = 0;
        #1;
        model_reset();
        check("rst_root", root, 0);
        check("rst_busy", busy, 0);
        check("rst_odd", odd, 0);
        check("rst_inc", neighbor_increase, 0);
        check("rst_out", output_data, 0);
        @(negedge clk) reset = 1;

        input_address = 6'd5;
        go(STAGE_MEASUREMENT_LOADING); go(STAGE_IDLE);
        check("load_root5", root, 6'd5);
        go(STAGE_MERGE); go(STAGE_MERGE);
        reset = 0;
        #1;
        check("midrst_root", root, 0);
        check("midrst_busy", busy, 0);
        check("midrst_odd", odd, 0);
        model_reset();
        global_stage = STAGE_IDLE;
        @(negedge clk) reset = 1;
        input_address = 6'b100011; measurement = 1;
        go(STAGE_MEASUREMENT_LOADING); go(STAGE_IDLE);
        check("load_root", root, 6'b100011);
        check("load_odd", odd, 1);

        go(STAGE_GROW);
        check("grow_pulse", neighbor_increase, 6'b111111);
        go(STAGE_GROW);
        check("grow_once", neighbor_increase, 0);
        go(STAGE_IDLE);
        measurement = 0;
        go(STAGE_MEASUREMENT_LOADING); go(STAGE_IDLE);
        go(STAGE_GROW);
        check("grow_even", neighbor_increase, 0);
        go(STAGE_IDLE);

        input_address = 6'b100101; measurement = 0;
        go(STAGE_MEASUREMENT_LOADING); go(STAGE_IDLE);
        fully = 6'b010100;
        nbr_root[2] = 6'b100001; nbr_root[4] = 6'b100001;
        go(STAGE_MERGE); go(STAGE_MERGE);
        check("merge_root", root, 6'b100001);
        check("merge_pv", get_pv(), 6'b000100);
        check("merge_busy", busy, 1);
        go(STAGE_IDLE);
        check("merge_idle", busy, 0);

        fully = 0;
        input_address = 6'b100011; measurement = 1;
        go(STAGE_MEASUREMENT_LOADING); go(STAGE_IDLE);
        fully = 6'b000010; bnd = 6'b000010;
        go(STAGE_MERGE); go(STAGE_PEELING);
        check("bnd_odd", odd, 0);
        check("bnd_root", root, 6'b000011);
        check("bnd_err", neighbor_is_error, 6'b000010);
        go(STAGE_IDLE);
        fully = 0; bnd = 0;

        addrs[0] = 6'h21; addrs[1] = 6'h12; addrs[2] = 6'h33;
        for (int k = 0; k < 3; k++) begin
            input_address = addrs[k];
            measurement = (k == 0);
            go(STAGE_MEASUREMENT_LOADING); go(STAGE_WRITE_TO_MEM); go(STAGE_IDLE);
        end
        go(STAGE_READ_FROM_MEM); go(STAGE_IDLE);
        check("ctx_root", root, 6'h21);
        check("ctx_m", measurement_out, 1);

        input_address = 6'b100111; measurement = 1;
        go(STAGE_MEASUREMENT_LOADING); go(STAGE_IDLE);
        fully = 6'b100000; nbr_root[5] = 6'b100000; nbr_odd[5] = 1;
        go(STAGE_MERGE); go(STAGE_IDLE);
        check("loc_pv", get_pv(), 6'b100000);
        fully = 0;
        local_sw = 1;
        go(STAGE_WRITE_TO_MEM); go(STAGE_READ_FROM_MEM); go(STAGE_IDLE);
        check("loc_swap", get_pv(), 6'b010000);
        local_sw = 0;
        go(STAGE_GROW);
        check("loc_grow1", neighbor_increase, 6'b111111);
        go(STAGE_IDLE);
        go(STAGE_GROW);
        check("loc_grow2", neighbor_increase, 6'b110000);
        go(STAGE_IDLE);

        for (int t = 0; t < 400; t++) begin
            measurement = 1'($urandom);
            local_sw = ($urandom_range(0, 3) == 0);
            input_address = 6'($urandom);
            fully = 6'($urandom);
            bnd = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            nbr_par = 6'($urandom);
            nbr_odd = 6'($urandom);
            nbr_cp = 6'($urandom);
            for (int i = 0; i < N; i++) nbr_root[i] = 6'($urandom);
            go(3'($urandom_range(0, 6)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
